// File: rtl/com_pkg.sv
// com_pkg: shared types and sizing constants for the centroid tracker and its consumers.
package com_pkg;
    typedef enum logic {IDLE = 1'b0, DIVIDE = 1'b1} com_state_t;
    localparam int COM_H_ACTIVE = 1024;
    localparam int COM_V_ACTIVE = 768;
    localparam int COM_SUM_W = 32;
    localparam int COM_CNT_W = 20;
endpackage

// File: rtl/center_of_mass_if.sv
// center_of_mass_if: pixel stream in, centroid result out.
interface center_of_mass_if
    import com_pkg::*;
#(
    parameter int CNT_W = COM_CNT_W
);
    logic [10:0]      x_in;
    logic [9:0]       y_in;
    logic             valid_in;
    logic             tabulate_in;
    logic [10:0]      x_out;
    logic [9:0]       y_out;
    logic [CNT_W-1:0] count_out;
    logic             valid_out;
    logic             busy_out;
    modport master (output x_in, y_in, valid_in, tabulate_in,
                    input x_out, y_out, count_out, valid_out, busy_out);
    modport slave (input x_in, y_in, valid_in, tabulate_in,
                   output x_out, y_out, count_out, valid_out, busy_out);
endinterface

// File: rtl/com_divider.sv
// com_divider: restoring divider, one quotient bit per cycle, SUM_W cycles after start.
module com_divider
    import com_pkg::*;
#(
    parameter int SUM_W = COM_SUM_W,
    parameter int OUT_W = SUM_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [SUM_W-1:0] divisor_i,
    output logic [OUT_W-1:0] quotient_o,
    output logic             done_o
);
    localparam int STEP_W = $clog2(SUM_W);
    logic [SUM_W-1:0]  rem_q, quo_q, div_q, rem_n;
    logic [STEP_W-1:0] step_q;
    logic              run_q, done_q, fits;
    logic [SUM_W:0]    shifted;
    // The true remainder is below the divisor, so the subtraction fits in SUM_W bits.
    always_comb begin
        shifted = {rem_q, quo_q[SUM_W-1]};
        fits = shifted >= {1'b0, div_q};
        rem_n = shifted[SUM_W-1:0] - (fits ? div_q : '0);
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rem_q <= '0;
            quo_q <= '0;
            div_q <= '0;
            step_q <= '0;
            run_q <= 1'b0;
            done_q <= 1'b0;
        end else if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            div_q <= divisor_i;
            step_q <= '0;
            run_q <= 1'b1;
            done_q <= 1'b0;
        end else if (run_q) begin
            rem_q <= rem_n;
            quo_q <= {quo_q[SUM_W-2:0], fits};
            step_q <= step_q + STEP_W'(1);
            run_q <= step_q != STEP_W'(SUM_W - 1);
            done_q <= step_q == STEP_W'(SUM_W - 1);
        end else begin
            done_q <= 1'b0;
        end
    end
    assign quotient_o = quo_q[OUT_W-1:0];
    assign done_o = done_q;
endmodule

// File: rtl/center_of_mass.sv
// center_of_mass: accumulates marker-pixel coordinates per frame and publishes their average.
module center_of_mass
    import com_pkg::*;
#(
    parameter int H_ACTIVE = COM_H_ACTIVE,
    parameter int V_ACTIVE = COM_V_ACTIVE,
    parameter int SUM_W    = COM_SUM_W,
    parameter int CNT_W    = COM_CNT_W
) (
    input logic              clk_in,
    input logic              rst_n_in,
    center_of_mass_if.slave  bus
);
    com_state_t       state_q, state_d;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_y_q, sum_y_d, acc_x, acc_y;
    logic [CNT_W-1:0] cnt_q, cnt_d, acc_cnt, snap_q, snap_d, count_q;
    logic [10:0]      x_q, qx;
    logic [9:0]       y_q, qy;
    logic             valid_q, take, tab, start, finish, done_x, done_y;
    // The pixel sampled with tabulate joins the closing frame, so snapshot the post-add values.
    always_comb begin
        take = bus.valid_in && 32'(bus.x_in) < H_ACTIVE && 32'(bus.y_in) < V_ACTIVE && cnt_q != '1;
        acc_x = take ? sum_x_q + SUM_W'(bus.x_in) : sum_x_q;
        acc_y = take ? sum_y_q + SUM_W'(bus.y_in) : sum_y_q;
        acc_cnt = take ? cnt_q + CNT_W'(1) : cnt_q;
        tab = state_q == IDLE && bus.tabulate_in;
        start = tab && acc_cnt != '0;
        finish = state_q == DIVIDE && done_x && done_y;
        sum_x_d = tab ? '0 : acc_x;
        sum_y_d = tab ? '0 : acc_y;
        cnt_d = tab ? '0 : acc_cnt;
        snap_d = start ? acc_cnt : snap_q;
        state_d = start ? DIVIDE : finish ? IDLE : state_q;
    end
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            sum_x_q <= '0;
            sum_y_q <= '0;
            cnt_q <= '0;
            snap_q <= '0;
            count_q <= '0;
            x_q <= '0;
            y_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
            cnt_q <= cnt_d;
            snap_q <= snap_d;
            valid_q <= finish;
            if (finish) begin
                x_q <= qx;
                y_q <= qy;
                count_q <= snap_q;
            end
        end
    end
    com_divider #(.SUM_W(SUM_W), .OUT_W(11)) u_div_x (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_i(start), .dividend_i(acc_x),
        .divisor_i(SUM_W'(acc_cnt)), .quotient_o(qx), .done_o(done_x)
    );
    com_divider #(.SUM_W(SUM_W), .OUT_W(10)) u_div_y (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_i(start), .dividend_i(acc_y),
        .divisor_i(SUM_W'(acc_cnt)), .quotient_o(qy), .done_o(done_y)
    );
    assign bus.x_out = x_q;
    assign bus.y_out = y_q;
    assign bus.count_out = count_q;
    assign bus.valid_out = valid_q;
    assign bus.busy_out = state_q == DIVIDE;
endmodule

// File: doc/center_of_mass.md
# center_of_mass

Frame-level centroid tracker. It sits directly upstream of the angle-checking stage and supplies the `x_com`/`y_com` reference point against which per-pixel angles are computed. While pixels of a frame stream in, it accumulates the coordinates of all pixels flagged as marker pixels. On a frame-end strobe it divides the coordinate sums by the pixel count and publishes the average position with a one-cycle valid pulse.

## Interface
Parameters:
- `H_ACTIVE`, default 1024: horizontal active pixels; pixels with `x_in >= H_ACTIVE` are ignored.
- `V_ACTIVE`, default 768: vertical active lines; pixels with `y_in >= V_ACTIVE` are ignored.
- `SUM_W`, default 32: width of the x/y sum accumulators and of the divider datapath.
- `CNT_W`, default 20: width of the pixel counter.

Ports:
- `clk_in`  in  1  single system clock; all logic is on its rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `x_in`  in  11  pixel column.
- `y_in`  in  10  pixel row.
- `valid_in`  in  1  current pixel is a marker pixel and is to be accumulated.
- `tabulate_in`  in  1  frame-end strobe, one cycle wide.
- `x_out`  out  11  centroid column.
- `y_out`  out  10  centroid row.
- `count_out`  out  CNT_W  pixel count of the tabulated frame.
- `valid_out`  out  1  one-cycle pulse: `x_out`/`y_out`/`count_out` updated.
- `busy_out`  out  1  division in progress.

## Operation
- Accumulation runs in every state. When `valid_in` is high and the pixel is in range:
  - `sum_x += x_in`
  - `sum_y += y_in`
  - `cnt += 1`
- Counter saturation: when `cnt` equals 2^CNT_W−1, further pixels are dropped. All three accumulators freeze together.
- States: IDLE, DIVIDE.
- IDLE, with `tabulate_in` high:
  - If `cnt == 0`: no division, no `valid_out`, outputs hold, accumulators cleared, remain in IDLE.
  - Otherwise: snapshot `sum_x`, `sum_y` and `cnt` into the divider operands. Clear the accumulators in the same edge, then go to DIVIDE.
- Coincident pixel: when `valid_in` and `tabulate_in` are high in the same cycle, that pixel belongs to the closing frame and is included in the snapshot.
- DIVIDE: two restoring dividers run in parallel and produce 1 quotient bit per cycle, SUM_W cycles in total. When both finish:
  - `x_out` ← quotient_x[10:0]
  - `y_out` ← quotient_y[9:0]
  - `count_out` ← snapshotted count
  - pulse `valid_out`, return to IDLE.
- Quotients truncate; there is no rounding. The quotient is guaranteed < H_ACTIVE / V_ACTIVE, so the truncation to 11/10 bits is lossless.
- `tabulate_in` while in DIVIDE is ignored. The accumulators are not cleared, so the next accepted tabulate covers both frames.
- Reset (asynchronous, any time, including mid-division):
  - All outputs go to 0 and the state goes to IDLE.
  - Accumulators and divider state are cleared.
  - No `valid_out` for the aborted division.

## Timing
- `tabulate_in` sampled at edge T (IDLE, `cnt > 0`):
  - `busy_out` is high from T+1 through T+SUM_W+1.
  - `valid_out` is high during the single cycle following edge T+SUM_W+1, i.e. latency SUM_W+2 = 34 cycles at default.
  - New outputs are visible in the same cycle as `valid_out` and held until the next `valid_out` or reset.
- The earliest next tabulate accepted is the cycle in which `valid_out` is high (state is already IDLE).
- Reset values:
  - `x_out`, `y_out`, `count_out`: 0
  - `valid_out`, `busy_out`: 0
- `valid_out` never stays high for two consecutive cycles.

## Structure
- Shared package `com_pkg` holds:
  - the state enum `com_state_t` {IDLE, DIVIDE};
  - the default `H_ACTIVE`/`V_ACTIVE`;
  - SUM_W/CNT_W localparams, so that the downstream stage sizes its inputs consistently.
- Sub-module `com_divider`: SUM_W-bit restoring divider.
  - Inputs: `start`, dividend, divisor (zero-extended count).
  - Outputs: quotient, `done` pulse.
  - Instantiated twice, for x and y.
  - Same clock and asynchronous active-low reset as the parent.

## Test plan
- Single pixel (100, 50), then tabulate → after 34 cycles `valid_out` = 1 for 1 cycle with `x_out` = 100, `y_out` = 50, `count_out` = 1.
- Pixels (10,20), (11,21), (13,22), then tabulate → `x_out` = 11 (34/3 truncated), `y_out` = 21, `count_out` = 3.
- Tabulate with no pixels after a prior result of (11, 21) → no `valid_out` within 40 cycles; outputs stay (11, 21, 3).
- Pixel (200,100) coincident with tabulate, then pixel (400,300) during DIVIDE plus a second tabulate during DIVIDE:
  - First result is (200, 100), count 1.
  - Next tabulate in IDLE yields (400, 300), count 1.
- Pixel x = 1024 (out of range) plus pixel (8, 8), then tabulate → (8, 8), count 1.
- `rst_n_in` low 10 cycles into DIVIDE:
  - Outputs are 0 immediately, asynchronously.
  - After release, no `valid_out`.
  - A fresh single pixel (5, 5) plus tabulate → (5, 5), count 1.
